// File: rtl/mem_request_arbiter_pkg.sv
// Command encoding and default sizing shared by the arbiter and the CPU front end.
// A command with its MSB set is a write (no response); MSB clear is a read (one response).
package mem_request_arbiter_pkg;

  localparam int CMD_BITS      = 2;
  localparam int DATA_BITS     = 2;
  localparam int MAX_READS     = 2;
  localparam int CMD_WRITE_BIT = CMD_BITS - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic logic is_write(input logic [CMD_BITS-1:0] cmd);
    return cmd[CMD_WRITE_BIT];
  endfunction

  function automatic logic is_read(input logic [CMD_BITS-1:0] cmd);
    return !cmd[CMD_WRITE_BIT];
  endfunction

endpackage

// File: rtl/mem_request_arbiter_owner_fifo.sv
// Circular FIFO of 1-bit owner tags, one per read still waiting for its response.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mem_owner_fifo #(
  parameter int DEPTH    = 2,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                din,
  output logic                head,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]    slots;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] ptr);
    return (ptr == PTR_BITS'(DEPTH - 1)) ? '0 : ptr + PTR_BITS'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_BITS'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin share of one memory_interface TX channel between fetch (port 0) and
// load/store (port 1); in-order read responses are steered back by an owner FIFO.
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int TX_CMD_BITS     = CMD_BITS,
  parameter int IO_BITS         = DATA_BITS,
  parameter int MAX_OUTSTANDING = MAX_READS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           req_valid,
  input  logic [2*TX_CMD_BITS-1:0]             req_cmd,
  output logic [1:0]                           req_started,
  input  logic [2*IO_BITS-1:0]                 req_tx_data,
  output logic [1:0]                           req_tx_data_next,
  output logic [1:0]                           req_rx_valid,
  output logic [1:0]                           req_rx_done,
  output logic                                 tx_command_valid,
  output logic [TX_CMD_BITS-1:0]               tx_command,
  output logic [IO_BITS-1:0]                   tx_data,
  input  logic                                 tx_command_started,
  input  logic                                 tx_active,
  input  logic                                 tx_data_next,
  input  logic                                 tx_done,
  input  logic                                 rx_started,
  input  logic                                 rx_data_valid,
  input  logic                                 rx_done,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 rx_unexpected,
  output logic                                 state
);

  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING) + 1;

  // Handshake: a command is offered while tx_command_valid is high and is taken
  // in the cycle memory_interface raises tx_command_started; no later back-pressure.
  arb_state_t              fsm;
  logic                    last_grant;
  logic                    owner;
  logic [TX_CMD_BITS-1:0]  cmd_latch;
  logic [TX_CMD_BITS-1:0]  cmd0;
  logic [TX_CMD_BITS-1:0]  cmd1;
  logic [TX_CMD_BITS-1:0]  grant_cmd;
  logic [1:0]              eligible;
  logic                    cap_ok;
  logic                    grant;
  logic                    start;
  logic                    push;
  logic                    pop;
  logic                    data_sel;
  logic                    fifo_head;
  logic                    fifo_empty;
  logic                    rx_drop;
  logic                    rx_route;
  logic                    orphan_start;
  logic                    unused_ok;

  assign unused_ok = tx_active;
  assign state     = fsm;

  assign cmd0   = req_cmd[0 +: TX_CMD_BITS];
  assign cmd1   = req_cmd[TX_CMD_BITS +: TX_CMD_BITS];
  // Registered count only: a read blocked at the cap waits one cycle after rx_done.
  assign cap_ok = (outstanding < CNT_BITS'(MAX_OUTSTANDING));

  assign eligible[0] = req_valid[0] && (is_write(cmd0) || cap_ok);
  assign eligible[1] = req_valid[1] && (is_write(cmd1) || cap_ok);

  always_comb begin
    grant = 1'b0;
    if (&eligible) begin
      grant = ~last_grant;
    end else if (eligible[1]) begin
      grant = 1'b1;
    end
  end

  assign grant_cmd        = grant ? cmd1 : cmd0;
  assign tx_command_valid = (fsm == ST_IDLE) && (|eligible);
  assign start            = tx_command_valid && tx_command_started;
  assign req_started      = start ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign push             = start && is_read(grant_cmd);

  assign tx_command = (fsm == ST_BUSY) ? cmd_latch : grant_cmd;
  assign data_sel   = (fsm == ST_BUSY) ? owner : grant;
  assign tx_data    = data_sel ? req_tx_data[IO_BITS +: IO_BITS] : req_tx_data[0 +: IO_BITS];

  assign req_tx_data_next = ((fsm == ST_BUSY) && tx_data_next) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_latch  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            fsm        <= ST_BUSY;
            owner      <= grant;
            cmd_latch  <= grant_cmd;
            last_grant <= grant;
          end
        end
        ST_BUSY: begin
          if (tx_done) begin
            fsm <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // A response nobody asked for is swallowed until its rx_done.
  assign orphan_start = rx_started && fifo_empty && !push;
  assign rx_route     = !fifo_empty && !rx_drop;
  assign pop          = rx_done && rx_route;
  assign req_rx_valid = (rx_route && rx_data_valid) ? (fifo_head ? 2'b10 : 2'b01) : 2'b00;
  assign req_rx_done  = (rx_route && rx_done) ? (fifo_head ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_drop       <= 1'b0;
      rx_unexpected <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_drop <= 1'b0;
      end else if (orphan_start) begin
        rx_drop <= 1'b1;
      end
      if (orphan_start || (rx_done && fifo_empty && !rx_drop)) begin
        rx_unexpected <= 1'b1;
      end
    end
  end

  mem_owner_fifo #(
    .DEPTH    (MAX_OUTSTANDING),
    .CNT_BITS (CNT_BITS)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .head  (fifo_head),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed and randomized checks of mem_request_arbiter against a queue-based owner model.
module tb_mem_request_arbiter;

  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_cmd;
  logic [1:0] req_started;
  logic [3:0] req_tx_data;
  logic [1:0] req_tx_data_next;
  logic [1:0] req_rx_valid;
  logic [1:0] req_rx_done;
  logic       tx_command_valid;
  logic [1:0] tx_command;
  logic [1:0] tx_data;
  logic       tx_command_started;
  logic       tx_active;
  logic       tx_data_next;
  logic       tx_done;
  logic       rx_started;
  logic       rx_data_valid;
  logic       rx_done;
  logic [1:0] outstanding;
  logic       rx_unexpected;
  logic       state;

  int tests = 0;
  int fails = 0;

  // Reference model: owners of unanswered reads in issue order, last grant, sticky error.
  logic model_q[$];
  logic model_last;
  logic model_unexp;

  mem_request_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_cmd            (req_cmd),
    .req_started        (req_started),
    .req_tx_data        (req_tx_data),
    .req_tx_data_next   (req_tx_data_next),
    .req_rx_valid       (req_rx_valid),
    .req_rx_done        (req_rx_done),
    .tx_command_valid   (tx_command_valid),
    .tx_command         (tx_command),
    .tx_data            (tx_data),
    .tx_command_started (tx_command_started),
    .tx_active          (tx_active),
    .tx_data_next       (tx_data_next),
    .tx_done            (tx_done),
    .rx_started         (rx_started),
    .rx_data_valid      (rx_data_valid),
    .rx_done            (rx_done),
    .outstanding        (outstanding),
    .rx_unexpected      (rx_unexpected),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid          = '0;
    req_cmd            = '0;
    req_tx_data        = '0;
    tx_command_started = 1'b0;
    tx_active          = 1'b0;
    tx_data_next       = 1'b0;
    tx_done            = 1'b0;
    rx_started         = 1'b0;
    rx_data_valid      = 1'b0;
    rx_done            = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_last  = 1'b1;
    model_unexp = 1'b0;
  endtask

  // One full TX transaction as memory_interface would run it, starting in IDLE.
  task automatic issue(input logic [1:0] v, input logic [3:0] cmds, input logic [3:0] data);
    logic [1:0] elig;
    logic       g;
    logic [1:0] gcmd;
    req_valid   = v;
    req_cmd     = cmds;
    req_tx_data = data;
    #1;
    for (int p = 0; p < 2; p++) begin
      elig[p] = v[p] && (cmds[2*p+1] || (model_q.size() < MAXO));
    end
    check("cmd_valid", tx_command_valid, {31'b0, |elig});
    if (elig == 2'b00) begin
      req_valid = '0;
      tick();
      return;
    end
    g    = (elig == 2'b11) ? ~model_last : elig[1];
    gcmd = g ? cmds[3:2] : cmds[1:0];
    check("tx_command", tx_command, gcmd);
    tx_command_started = 1'b1;
    #1;
    check("req_started", req_started, g ? 2'b10 : 2'b01);
    tick();
    tx_command_started = 1'b0;
    tx_active          = 1'b1;
    req_valid          = '0;
    req_cmd            = ~cmds;
    model_last         = g;
    if (!gcmd[1]) model_q.push_back(g);
    #1;
    check("busy_valid", tx_command_valid, 0);
    check("busy_state", state, 1);
    check("latched_cmd", tx_command, gcmd);
    check("outstanding_issue", outstanding, model_q.size());
    tx_data_next = 1'b1;
    #1;
    check("data_next", req_tx_data_next, g ? 2'b10 : 2'b01);
    check("tx_data", tx_data, g ? data[3:2] : data[1:0]);
    check("held_cmd", tx_command, gcmd);
    tick();
    tx_data_next = 1'b0;
    tx_done      = 1'b1;
    tick();
    tx_done   = 1'b0;
    tx_active = 1'b0;
  endtask

  // One in-order RX response: start, one data beat, done.
  task automatic respond();
    logic       had;
    logic       h;
    logic [1:0] exp_route;
    had = (model_q.size() > 0);
    h   = had ? model_q[0] : 1'b0;
    exp_route = had ? (h ? 2'b10 : 2'b01) : 2'b00;
    if (!had) model_unexp = 1'b1;
    rx_started = 1'b1;
    tick();
    rx_started    = 1'b0;
    rx_data_valid = 1'b1;
    #1;
    check("rx_valid_route", req_rx_valid, exp_route);
    check("rx_unexpected", rx_unexpected, model_unexp);
    tick();
    rx_data_valid = 1'b0;
    rx_done       = 1'b1;
    #1;
    check("rx_done_route", req_rx_done, exp_route);
    tick();
    rx_done = 1'b0;
    if (had) void'(model_q.pop_front());
    #1;
    check("outstanding_resp", outstanding, model_q.size());
    check("rx_unexpected_after", rx_unexpected, model_unexp);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outstanding", outstanding, 0);
    check("reset_unexpected", rx_unexpected, 0);
    check("reset_state", state, 0);
    check("reset_cmd_valid", tx_command_valid, 0);
    check("reset_req_outs", {req_started, req_tx_data_next, req_rx_valid, req_rx_done}, 0);
    reset = 1'b0;
    tick();

    // Port 0 read alone, then its response.
    issue(2'b01, 4'b0000, 4'b0001);
    respond();

    // Both ports reading: grants alternate, responses come back in issue order.
    issue(2'b11, 4'b0000, 4'b1001);
    issue(2'b11, 4'b0000, 4'b1001);
    respond();
    respond();
    issue(2'b11, 4'b0000, 4'b0110);
    issue(2'b11, 4'b0000, 4'b0110);
    respond();
    respond();

    // Fill to the cap, then a third read stays blocked through the rx_done cycle.
    issue(2'b01, 4'b0000, 4'b0010);
    issue(2'b01, 4'b0000, 4'b0011);
    check("cap_full", outstanding, 2);
    req_valid  = 2'b01;
    req_cmd    = 4'b0000;
    rx_started = 1'b1;
    #1;
    check("cap_block_start", tx_command_valid, 0);
    tick();
    rx_started    = 1'b0;
    rx_data_valid = 1'b1;
    #1;
    check("cap_block_data", tx_command_valid, 0);
    tick();
    rx_data_valid = 1'b0;
    rx_done       = 1'b1;
    #1;
    check("cap_block_on_done", tx_command_valid, 0);
    check("cap_done_route", req_rx_done, model_q[0] ? 2'b10 : 2'b01);
    tick();
    rx_done = 1'b0;
    void'(model_q.pop_front());
    #1;
    check("cap_release", tx_command_valid, 1);
    check("cap_outstanding", outstanding, 1);
    issue(2'b01, 4'b0000, 4'b0001);
    check("cap_refill", outstanding, 2);

    // Port 1 write at the cap starts at once, no push, port 0 data kept off tx_data.
    issue(2'b10, 4'b1000, 4'b1001);
    check("write_no_push", outstanding, 2);
    respond();
    respond();

    // Randomized mix of requests and responses.
    for (int i = 0; i < 60; i++) begin
      if ((model_q.size() > 0) && ($urandom_range(0, 2) == 0)) begin
        respond();
      end else begin
        issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    while (model_q.size() > 0) respond();

    // Response with nothing outstanding: flagged, not routed, and sticky.
    respond();
    repeat (3) tick();
    check("unexp_sticky", rx_unexpected, 1);

    // Reset while BUSY with one read outstanding.
    req_valid   = 2'b01;
    req_cmd     = 4'b0000;
    req_tx_data = 4'b0000;
    #1;
    tx_command_started = 1'b1;
    tick();
    tx_command_started = 1'b0;
    req_valid          = '0;
    tx_active          = 1'b1;
    #1;
    check("pre_reset_state", state, 1);
    check("pre_reset_outstanding", outstanding, 1);
    tx_data_next = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_outstanding", outstanding, 0);
    check("async_unexpected", rx_unexpected, 0);
    check("async_cmd_valid", tx_command_valid, 0);
    check("async_req_outs", {req_started, req_tx_data_next, req_rx_valid, req_rx_done}, 0);
    model_reset();
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();

    // After reset, port 0 wins the first tie again.
    issue(2'b11, 4'b0000, 4'b1101);
    respond();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
